axis_pulse_gen: RTL

AXI4-Stream master that emits rectangular pulses into a continuous sample stream, typically feeding a DAC path.
- Baseline is zero-valued samples.
- On a start request it outputs a configured amplitude for a configured number of accepted beats.
- It flags the first pulse beat as a trigger for downstream capture and measurement blocks, and reports the number of pulse beats actually delivered.

---
 rtl/axis_pulse_gen.sv | 123 ++++++++++++
 1 files changed

// File: rtl/axis_pulse_gen.sv
// AXI4-Stream rectangular pulse source: zero baseline, a latched amplitude for a
// configured number of accepted beats, a first-beat trigger strobe and a delivered-beat count.
module axis_pulse_gen #(
    parameter int unsigned CNTR_WIDTH       = 64,
    parameter int unsigned AXIS_TDATA_WIDTH = 16
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        run_flag,
    input  logic                        cfg_flag,
    input  logic [CNTR_WIDTH-1:0]       cfg_data,
    input  logic [AXIS_TDATA_WIDTH-1:0] cfg_amp,
    output logic                        trg_flag,
    output logic [CNTR_WIDTH-1:0]       sts_data,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_PULSE = 1'b1
    } state_t;

    localparam logic [CNTR_WIDTH-1:0]       CNT_ZERO  = {CNTR_WIDTH{1'b0}};
    localparam logic [CNTR_WIDTH-1:0]       CNT_ONE   = {{(CNTR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [AXIS_TDATA_WIDTH-1:0] DATA_ZERO = {AXIS_TDATA_WIDTH{1'b0}};

    state_t                        state_q,     state_d;
    logic                          cfg_flag_q,  cfg_flag_d;
    logic [CNTR_WIDTH-1:0]         remaining_q, remaining_d;
    logic [AXIS_TDATA_WIDTH-1:0]   amp_q,       amp_d;
    logic [AXIS_TDATA_WIDTH-1:0]   tdata_q,     tdata_d;
    logic                          tvalid_q,    tvalid_d;
    logic                          trg_q,       trg_d;
    logic [CNTR_WIDTH-1:0]         sts_q,       sts_d;

    logic start_s;
    logic start_ok_s;
    logic beat_s;
    logic last_beat_s;

    assign start_s     = cfg_flag & ~cfg_flag_q;
    assign start_ok_s  = run_flag & start_s & (cfg_data != CNT_ZERO);
    assign beat_s      = tvalid_q & m_axis_tready;
    assign last_beat_s = beat_s & (remaining_q == CNT_ONE);

    // Next-state and registered-output logic for the idle/pulse machine.
    always_comb begin
        state_d     = state_q;
        cfg_flag_d  = cfg_flag;
        remaining_d = remaining_q;
        amp_d       = amp_q;
        tdata_d     = tdata_q;
        tvalid_d    = run_flag;
        trg_d       = 1'b0;
        sts_d       = sts_q;

        case (state_q)
            ST_IDLE: begin
                if (start_ok_s) begin
                    remaining_d = cfg_data;
                    amp_d       = cfg_amp;
                    sts_d       = CNT_ZERO;
                    tdata_d     = cfg_amp;
                    state_d     = ST_PULSE;
                end else begin
                    tdata_d     = DATA_ZERO;
                end
            end
            ST_PULSE: begin
                // A beat accepted in the same cycle run_flag drops still counts as delivered.
                if (beat_s && (remaining_q != CNT_ZERO)) begin
                    sts_d       = sts_q + CNT_ONE;
                    remaining_d = remaining_q - CNT_ONE;
                    trg_d       = (sts_q == CNT_ZERO);
                end else begin
                    sts_d       = sts_q;
                    remaining_d = remaining_q;
                end
                if (!run_flag || last_beat_s) begin
                    state_d = ST_IDLE;
                    tdata_d = DATA_ZERO;
                end else begin
                    tdata_d = amp_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tdata_d = DATA_ZERO;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= ST_IDLE;
            cfg_flag_q  <= 1'b0;
            remaining_q <= CNT_ZERO;
            amp_q       <= DATA_ZERO;
            tdata_q     <= DATA_ZERO;
            tvalid_q    <= 1'b0;
            trg_q       <= 1'b0;
            sts_q       <= CNT_ZERO;
        end else begin
            state_q     <= state_d;
            cfg_flag_q  <= cfg_flag_d;
            remaining_q <= remaining_d;
            amp_q       <= amp_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            trg_q       <= trg_d;
            sts_q       <= sts_d;
        end
    end

    assign trg_flag      = trg_q;
    assign sts_data      = sts_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;

endmodule
